// File: rtl/uart_tx_fifo_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg: shared definitions for the UART transmit FIFO / launch sequencer.
//   tx_state_t  : launch sequencer states
//   UART_WIDTH  : default data bits per UART character
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } tx_state_t;

    localparam int UART_WIDTH = 8;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo_if: producer-side push signals and transmitter-side launch
// signals of the UART transmit FIFO.
//   slave  : the FIFO itself (takes wr_en/wr_data/tx_busy, drives the rest)
//   master : producer + transmitter side
// Signals:
//   wr_en, wr_data   push request and byte
//   full, empty      occupancy flags, combinational from count
//   count            stored entries 0..DEPTH
//   overflow         one-cycle pulse when a push is dropped
//   tx_data          byte presented to the transmitter (registered)
//   tx_start         one-cycle launch pulse (registered)
//   tx_busy          transmitter busy, synchronous to clk
//   timeout          one-cycle pulse when a launch is abandoned
// ---------------------------------------------------------------------------
interface uart_tx_fifo_if #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
);
    logic                     wr_en;
    logic [WIDTH-1:0]         wr_data;
    logic                     full;
    logic                     empty;
    logic [$clog2(DEPTH):0]   count;
    logic                     overflow;
    logic [WIDTH-1:0]         tx_data;
    logic                     tx_start;
    logic                     tx_busy;
    logic                     timeout;

    modport slave (
        input  wr_en, wr_data, tx_busy,
        output full, empty, count, overflow, tx_data, tx_start, timeout
    );

    modport master (
        output wr_en, wr_data, tx_busy,
        input  full, empty, count, overflow, tx_data, tx_start, timeout
    );
endinterface

// File: rtl/uart_tx_fifo_mem.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo_mem: DEPTH x WIDTH storage array for the UART transmit FIFO.
// Synchronous write port, combinational read port. No reset: contents are
// only meaningful between the pointers kept by the parent.
//   clk    clock
//   we     write enable
//   waddr  write address
//   wdata  write data
//   raddr  read address
//   rdata  read data (combinational)
// ---------------------------------------------------------------------------
module uart_tx_fifo_mem #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo: byte FIFO plus launch sequencer feeding a UART transmitter.
// Producers push at clock rate; the sequencer pops one byte at a time,
// pulses tx_start and follows tx_busy through the frame.
// Ports:
//   clk, rst   clock and asynchronous active-high reset
//   bus        uart_tx_fifo_if.slave (push side + transmitter side)
//   drop_cnt    (UART_TX_FIFO_STATS_EN only) saturating dropped-push count
//   timeout_cnt (UART_TX_FIFO_STATS_EN only) saturating abandoned-launch count
// Optional feature macro: UART_TX_FIFO_STATS_EN
// ---------------------------------------------------------------------------
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int WIDTH    = UART_WIDTH,
    parameter int WAIT_MAX = 1023
) (
    input  logic          clk,
    input  logic          rst,
`ifdef UART_TX_FIFO_STATS_EN
    output logic [15:0]   drop_cnt,
    output logic [7:0]    timeout_cnt,
`endif
    uart_tx_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int WW = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] rd_data;
    logic [WW-1:0]    wait_cnt;
    logic             is_full;
    logic             is_empty;
    logic             push;
    logic             drop;
    logic             pop;
    logic             give_up;
    tx_state_t        state;
    tx_state_t        state_nxt;

    assign is_full   = (count == CW'(DEPTH));
    assign is_empty  = (count == '0);
    assign bus.full  = is_full;
    assign bus.empty = is_empty;
    assign bus.count = count;

    // Full is judged on the pre-edge count, so a push while full is dropped
    // even when the sequencer pops in the same cycle.
    assign push = bus.wr_en && !is_full;
    assign drop = bus.wr_en && is_full;

    uart_tx_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (bus.wr_data),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        give_up   = 1'b0;
        case (state)
            IDLE: begin
                if (!is_empty && !bus.tx_busy) begin
                    pop       = 1'b1;
                    state_nxt = LAUNCH;
                end
            end
            LAUNCH: begin
                state_nxt = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (bus.tx_busy) begin
                    state_nxt = WAIT_DONE;
                end else if (wait_cnt == WW'(WAIT_MAX)) begin
                    // Transmitter never picked the byte up; it is lost.
                    give_up   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            wait_cnt     <= '0;
            bus.tx_data  <= '0;
            bus.tx_start <= 1'b0;
            bus.overflow <= 1'b0;
            bus.timeout  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr      <= rd_ptr + 1'b1;
                bus.tx_data <= rd_data;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            bus.tx_start <= pop;
            bus.overflow <= drop;
            bus.timeout  <= give_up;
            if (state == LAUNCH) begin
                wait_cnt <= '0;
            end else if (state == WAIT_BUSY && !bus.tx_busy && !give_up) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

`ifdef UART_TX_FIFO_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt    <= '0;
            timeout_cnt <= '0;
        end else begin
            if (drop && drop_cnt != 16'hFFFF) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
            if (give_up && timeout_cnt != 8'hFF) begin
                timeout_cnt <= timeout_cnt + 1'b1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_fifo: self-checking bench for uart_tx_fifo (DEPTH=16, WIDTH=8,
// WAIT_MAX=1023). A vector table covers single-cycle push/launch behaviour;
// hand-written sequences cover multi-cycle corner cases.
// ---------------------------------------------------------------------------
module tb_uart_tx_fifo;
    import uart_pkg::*;

    localparam int DEPTH    = 16;
    localparam int WIDTH    = 8;
    localparam int WAIT_MAX = 1023;
    localparam int BUSY_LEN = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;

    uart_tx_fifo_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

`ifdef UART_TX_FIFO_STATS_EN
    logic [15:0] drop_cnt;
    logic [7:0]  timeout_cnt;
`endif

    uart_tx_fifo #(
        .DEPTH    (DEPTH),
        .WIDTH    (WIDTH),
        .WAIT_MAX (WAIT_MAX)
    ) dut (
        .clk         (clk),
        .rst         (rst),
`ifdef UART_TX_FIFO_STATS_EN
        .drop_cnt    (drop_cnt),
        .timeout_cnt (timeout_cnt),
`endif
        .bus         (bus)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } launch_t;

    typedef struct {
        logic       wr_en;
        logic [7:0] wr_data;
        logic       busy;
        int         cnt;
        logic       full;
        logic       empty;
        logic       ovf;
        logic       start;
        logic [7:0] txd;
    } vec_t;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int ovf_seen = 0;
    int busy_left = 0;
    bit tx_auto = 1'b0;
    launch_t launches[$];
    int      falls[$];
    int      timeouts[$];
    vec_t    vecs[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Edge counter: after posedge k, cyc == k.
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: records launches, overflow and timeout pulses away from the edge.
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (bus.tx_start === 1'b1) launches.push_back('{bus.tx_data, cyc});
            if (bus.overflow === 1'b1) ovf_seen++;
            if (bus.timeout === 1'b1) timeouts.push_back(cyc);
        end
    end

    // Transmitter model: busy for BUSY_LEN cycles after each observed launch.
    initial forever begin
        @(posedge clk);
        #1;
        if (tx_auto) begin
            if (busy_left > 0) begin
                busy_left--;
                if (busy_left == 0) begin
                    bus.tx_busy = 1'b0;
                    falls.push_back(cyc);
                end
            end
            if (bus.tx_start === 1'b1) begin
                bus.tx_busy = 1'b1;
                busy_left   = BUSY_LEN;
            end
        end
    end

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        tx_auto = 1'b0;
        busy_left = 0;
        bus.tx_busy = 1'b0;
        bus.wr_en = 1'b0;
        bus.wr_data = '0;
        repeat (2) @(negedge clk);
        launches.delete();
        falls.delete();
        timeouts.delete();
        ovf_seen = 0;
        rst = 1'b0;
    endtask

    task automatic push(input logic [7:0] d);
        @(negedge clk);
        bus.wr_en = 1'b1;
        bus.wr_data = d;
        @(negedge clk);
        bus.wr_en = 1'b0;
    endtask

    initial begin
        bus.wr_en = 1'b0;
        bus.wr_data = '0;
        bus.tx_busy = 1'b0;

        vecs[0] = '{1'b1, 8'h12, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[1] = '{1'b0, 8'h00, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h12};
        vecs[2] = '{1'b0, 8'h00, 1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h12};
        vecs[3] = '{1'b1, 8'h34, 1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h12};
        vecs[4] = '{1'b1, 8'h56, 1'b1, 2, 1'b0, 1'b0, 1'b0, 1'b0, 8'h12};
        vecs[5] = '{1'b0, 8'h00, 1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b0, 8'h12};
        vecs[6] = '{1'b0, 8'h00, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h34};
        vecs[7] = '{1'b1, 8'h78, 1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b0, 8'h34};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_count", 32'(bus.count), 0);
        chk("rst_empty", 32'(bus.empty), 1);
        chk("rst_full", 32'(bus.full), 0);
        chk("rst_tx_start", 32'(bus.tx_start), 0);
        chk("rst_tx_data", 32'(bus.tx_data), 0);
        chk("rst_overflow", 32'(bus.overflow), 0);
        chk("rst_timeout", 32'(bus.timeout), 0);
        rst = 1'b0;

        // Vector table
        for (int i = 0; i < 8; i++) begin
            bus.wr_en   = vecs[i].wr_en;
            bus.wr_data = vecs[i].wr_data;
            bus.tx_busy = vecs[i].busy;
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("v%0d_count", i), 32'(bus.count), 32'(vecs[i].cnt));
            chk($sformatf("v%0d_full", i), 32'(bus.full), 32'(vecs[i].full));
            chk($sformatf("v%0d_empty", i), 32'(bus.empty), 32'(vecs[i].empty));
            chk($sformatf("v%0d_overflow", i), 32'(bus.overflow), 32'(vecs[i].ovf));
            chk($sformatf("v%0d_tx_start", i), 32'(bus.tx_start), 32'(vecs[i].start));
            chk($sformatf("v%0d_tx_data", i), 32'(bus.tx_data), 32'(vecs[i].txd));
        end
        bus.wr_en = 1'b0;

        // Four back-to-back pushes, modelled transmitter
        do_reset();
        tx_auto = 1'b1;
        @(negedge clk);
        bus.wr_en = 1'b1;
        bus.wr_data = 8'h12; @(negedge clk);
        bus.wr_data = 8'h34; @(negedge clk);
        bus.wr_data = 8'h56; @(negedge clk);
        bus.wr_data = 8'h11; @(negedge clk);
        bus.wr_en = 1'b0;
        for (int k = 0; k < 300 && launches.size() < 4; k++) settle(1);
        chk("seq_launch_n", 32'(launches.size()), 4);
        if (launches.size() >= 4) begin
            chk("seq_d0", 32'(launches[0].data), 32'h12);
            chk("seq_d1", 32'(launches[1].data), 32'h34);
            chk("seq_d2", 32'(launches[2].data), 32'h56);
            chk("seq_d3", 32'(launches[3].data), 32'h11);
            for (int k = 1; k < 4; k++) begin
                if (falls.size() >= k)
                    chk($sformatf("seq_gap%0d", k), 32'(launches[k].cyc - falls[k-1]), 2);
                else
                    chk($sformatf("seq_fall%0d", k), 32'(falls.size()), 32'(k));
            end
        end
        settle(30);
        chk("seq_count_end", 32'(bus.count), 0);

        // Overflow with transmitter held busy
        do_reset();
        bus.tx_busy = 1'b1;
        for (int k = 0; k < DEPTH; k++) push(8'h80 + 8'(k));
        chk("ovf_full", 32'(bus.full), 1);
        chk("ovf_count16", 32'(bus.count), 16);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            bus.wr_en = 1'b1;
            bus.wr_data = 8'h90 + 8'(k);
            @(negedge clk);
            chk($sformatf("ovf_pulse%0d", k), 32'(bus.overflow), 1);
            chk($sformatf("ovf_count_hold%0d", k), 32'(bus.count), 16);
            bus.wr_en = 1'b0;
        end
        @(negedge clk);
        chk("ovf_pulse_end", 32'(bus.overflow), 0);
`ifdef UART_TX_FIFO_STATS_EN
        chk("ovf_drop_cnt", 32'(drop_cnt), 2);
`endif
        bus.tx_busy = 1'b0;
        tx_auto = 1'b1;
        for (int k = 0; k < 1000 && launches.size() < DEPTH; k++) settle(1);
        settle(60);
        chk("ovf_seen", 32'(ovf_seen), 2);
        chk("ovf_launch_n", 32'(launches.size()), 32'(DEPTH));
        for (int k = 0; k < DEPTH && k < launches.size(); k++)
            chk($sformatf("ovf_d%0d", k), 32'(launches[k].data), 32'h80 + 32'(k));
        chk("ovf_empty_end", 32'(bus.empty), 1);

        // Launch timeout with transmitter never going busy
        do_reset();
        @(negedge clk);
        bus.wr_en = 1'b1;
        bus.wr_data = 8'hA0; @(negedge clk);
        bus.wr_data = 8'hA1; @(negedge clk);
        bus.wr_en = 1'b0;
        for (int k = 0; k < 1300 && launches.size() < 2; k++) settle(1);
        chk("to_n", 32'(timeouts.size()), 1);
        chk("to_launch_n", 32'(launches.size()), 2);
        if (timeouts.size() >= 1 && launches.size() >= 2) begin
            chk("to_latency", 32'(timeouts[0] - launches[0].cyc), 32'(WAIT_MAX + 2));
            chk("to_d0", 32'(launches[0].data), 32'hA0);
            chk("to_d1", 32'(launches[1].data), 32'hA1);
            chk("to_next", 32'(launches[1].cyc - timeouts[0]), 1);
        end
`ifdef UART_TX_FIFO_STATS_EN
        chk("to_timeout_cnt", 32'(timeout_cnt), 1);
`endif

        // Push while full coincident with a launch pop
        do_reset();
        bus.tx_busy = 1'b1;
        for (int k = 0; k < DEPTH; k++) push(8'hB0 + 8'(k));
        chk("fp_count16", 32'(bus.count), 16);
        @(negedge clk);
        bus.wr_en = 1'b1;
        bus.wr_data = 8'hEE;
        bus.tx_busy = 1'b0;
        @(negedge clk);
        bus.wr_en = 1'b0;
        bus.tx_busy = 1'b1;
        chk("fp_count15", 32'(bus.count), 15);
        chk("fp_overflow", 32'(bus.overflow), 1);
        chk("fp_tx_start", 32'(bus.tx_start), 1);
        chk("fp_tx_data", 32'(bus.tx_data), 32'hB0);

        // Reset while in WAIT_DONE with 5 queued bytes
        do_reset();
        push(8'hC0);
        @(negedge clk);
        bus.tx_busy = 1'b1;
        for (int k = 1; k <= 5; k++) push(8'hC0 + 8'(k));
        @(negedge clk);
        chk("rw_count5", 32'(bus.count), 5);
        chk("rw_state", 32'(dut.state), 32'(WAIT_DONE));
        #2;
        rst = 1'b1;
        #1;
        chk("rw_count0", 32'(bus.count), 0);
        chk("rw_empty", 32'(bus.empty), 1);
        chk("rw_tx_start", 32'(bus.tx_start), 0);
        @(negedge clk);
        rst = 1'b0;
        bus.tx_busy = 1'b0;
        begin
            int n0;
            n0 = launches.size();
            settle(6);
            chk("rw_no_launch", 32'(launches.size()), 32'(n0));
            push(8'hD0);
            settle(2);
            chk("rw_new_launch", 32'(launches.size()), 32'(n0 + 1));
            if (launches.size() == n0 + 1)
                chk("rw_new_data", 32'(launches[n0].data), 32'hD0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Byte FIFO and launch sequencer that sits directly upstream of the UART transmitter. Producers push bytes at system-clock rate. The block holds them in a circular buffer and hands them to the transmitter one at a time, using a start pulse and the transmitter's busy status. It replaces hard-coded shift-buffer feeding with a flow-controlled queue.

## Interface
- DEPTH, 16: FIFO entries; power of two, ≥ 2.
- WIDTH, 8: data bits per entry.
- WAIT_MAX, 1023: cycles to wait for tx_busy to rise after a launch before abandoning.

- clk  in  1  system clock; every register samples on its rising edge.
- rst  in  1  reset; one clock; reset is asynchronous and active-high.
- wr_en  in  1  push request.
- wr_data  in  WIDTH  byte to push.
- full  out  1  no free entry; combinational from count.
- empty  out  1  no stored entry; combinational from count.
- count  out  $clog2(DEPTH)+1  stored entries, 0..DEPTH.
- overflow  out  1  one-cycle pulse when a push is dropped.
- tx_data  out  WIDTH  byte presented to transmitter; registered.
- tx_start  out  1  one-cycle launch pulse; registered.
- tx_busy  in  1  transmitter busy; high from frame start to stop-bit end; synchronous to clk.
- timeout  out  1  one-cycle pulse when a launch is abandoned.

## Operation
- Storage: circular buffer with rd_ptr/wr_ptr of $clog2(DEPTH) bits; both wrap DEPTH-1 → 0. count is tracked separately.
- Push: if wr_en && !full, write mem[wr_ptr] and increment wr_ptr. If wr_en && full, drop the byte and pulse overflow; the stored contents are unchanged.
- Pop happens only inside the sequencer, on the IDLE → LAUNCH transition.
- Simultaneous push and pop: both take effect and count is unchanged. The full check uses the pre-edge count, so a push while full is dropped even if a pop occurs in the same cycle.
- Sequencer states:
  - IDLE: if !empty && !tx_busy, load tx_data ← mem[rd_ptr], increment rd_ptr, assert tx_start; go to LAUNCH.
  - LAUNCH: deassert tx_start; clear wait counter; go to WAIT_BUSY.
  - WAIT_BUSY: if tx_busy, go to WAIT_DONE. Else if wait counter == WAIT_MAX, pulse timeout and go to IDLE; the byte is lost. Else increment the wait counter.
  - WAIT_DONE: when !tx_busy, go to IDLE.
- tx_data holds its value until the next launch.
- Reset values: state IDLE, pointers 0, count 0, tx_data 0, tx_start 0, overflow 0, timeout 0. full=0 and empty=1 follow from count. Memory contents are not reset.
- Reset mid-operation: asynchronous reset discards queued bytes and forces IDLE immediately. A frame already in flight in the transmitter is not recalled.

## Timing
- A push at edge N is reflected in count/empty after edge N.
- With the FIFO empty, idle, and tx_busy low, a push at edge N gives tx_start=1 in cycle N+1 → N+2. This is 1-cycle push-to-launch latency.
- tx_start is high for exactly one cycle per popped byte.
- Back-to-back frames: the minimum gap from tx_busy falling to the next tx_start is 2 cycles (WAIT_DONE → IDLE → launch).
- overflow and timeout are single-cycle pulses, registered.

## Configuration
- UART_TX_FIFO_STATS_EN defined:
  - Adds output drop_cnt (16 bits), which counts dropped pushes and saturates at 16'hFFFF.
  - Adds output timeout_cnt (8 bits), which counts abandoned launches and saturates at 8'hFF.
  - Both counters clear on rst.
- Undefined: these ports and their counters do not exist. All other behaviour is identical.

## Structure
- Shared package uart_pkg holds:
  - the state enum (IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE);
  - UART_WIDTH = 8.
- One sub-module, uart_tx_fifo_mem: a DEPTH×WIDTH array with a synchronous write port and a combinational read port addressed by rd_ptr. It has no reset.

## Test plan
- Reset, then push 8'h12 with tx_busy low → tx_start pulses 1 cycle later, tx_data=8'h12, count returns to 0.
- Push 8'h12, 8'h34, 8'h56, 8'h11 back-to-back; model busy for 20 cycles per launch → four launches in order 12, 34, 56, 11, each ≥ 2 cycles after the prior busy fall.
- Hold tx_busy high and push DEPTH+2 bytes → full=1 at count 16, two overflow pulses, and bytes 17–18 are never transmitted.
- Launch with tx_busy never rising → timeout pulses after WAIT_MAX+1 WAIT_BUSY cycles, the next queued byte launches, and timeout_cnt=1 when UART_TX_FIFO_STATS_EN is defined.
- At full, push and launch-pop in the same cycle → push dropped with overflow, count becomes DEPTH-1.
- Assert rst while in WAIT_DONE with 5 queued bytes → immediately count=0, empty=1, tx_start=0; no launch until a new push.
